// File: rtl/mem_responder.sv
// Word-addressed memory responder: two pipelined read ports with write-first forwarding,
// one write port, and an optional clear-on-reset sequencer that gates the ready flag.
module mem_responder #(
  parameter int unsigned ADDR_W         = 15,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 0,
  parameter string       INIT_FILE      = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic {StClear, StRun} state_e;

  logic [DATA_W-1:0] mem_q [Depth];

  state_e            state_q;
  logic              ready_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic [DATA_W-1:0] stage1_0_q, stage1_1_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic              fwd0, fwd1;

  // The clear sequencer owns the write port while clearing; core writes need ready.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = waddr;
    mem_wd = wdata;
    if (rst_n) begin
      if (state_q == StClear) begin
        mem_we = 1'b1;
        mem_wa = clr_ptr_q;
        mem_wd = '0;
      end else if (ready_q && wen) begin
        mem_we = 1'b1;
      end
    end
  end

  assign fwd0 = ready_q && wen && (waddr == raddr0);
  assign fwd1 = ready_q && wen && (waddr == raddr1);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
      ready_q    <= 1'b0;
      clr_ptr_q  <= '0;
      stage1_0_q <= '0;
      stage1_1_q <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (&clr_ptr_q) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun: begin
          ready_q <= 1'b1;
        end
      endcase
      if (ready_q) begin
        stage1_0_q <= fwd0 ? wdata : mem_q[raddr0];
        stage1_1_q <= fwd1 ? wdata : mem_q[raddr1];
      end else begin
        stage1_0_q <= '0;
        stage1_1_q <= '0;
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    assign rdata0 = stage1_0_q;
    assign rdata1 = stage1_1_q;
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_W-1:0] stage2_0_q, stage2_1_q;

    // In-flight data is frozen at capture; later writes only affect new captures.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        stage2_0_q <= '0;
        stage2_1_q <= '0;
      end else begin
        stage2_0_q <= stage1_0_q;
        stage2_1_q <= stage1_1_q;
      end
    end

    assign rdata0 = stage2_0_q;
    assign rdata1 = stage2_1_q;
  end else begin : g_bad_latency
    $error("mem_responder: READ_LATENCY must be 1 or 2");
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (latency 1 with clear-on-reset, latency 2 without)
// share one stimulus stream and are checked each clock against a behavioural memory model.
module tb_mem_responder;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned N  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] raddr0, raddr1, waddr;
  logic          wen;
  logic [DW-1:0] wdata;

  logic [DW-1:0] rd0 [2];
  logic [DW-1:0] rd1 [2];
  logic          rdy_o [2];

  int checks   = 0;
  int failures = 0;

  // Model state: index 0 = latency 1 / clear-on-reset, index 1 = latency 2 / no clear.
  int            lat [2] = '{1, 2};
  bit            clr [2] = '{1'b1, 1'b0};
  logic [DW-1:0] mm  [2][N];
  bit            rdy [2] = '{1'b0, 1'b0};
  int            left[2] = '{0, 0};
  logic [DW-1:0] p0  [2][2];
  logic [DW-1:0] p1  [2][2];

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .CLEAR_ON_RESET(1), .INIT_FILE("")
  ) u_a (
    .clk(clk), .rst_n(rst_n), .raddr0(raddr0), .rdata0(rd0[0]), .raddr1(raddr1),
    .rdata1(rd1[0]), .wen(wen), .waddr(waddr), .wdata(wdata), .ready(rdy_o[0])
  );

  mem_responder #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2), .CLEAR_ON_RESET(0), .INIT_FILE("")
  ) u_b (
    .clk(clk), .rst_n(rst_n), .raddr0(raddr0), .rdata0(rd0[1]), .raddr1(raddr1),
    .rdata1(rd1[1]), .wen(wen), .waddr(waddr), .wdata(wdata), .ready(rdy_o[1])
  );

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      logic [DW-1:0] c0, c1;
      c0 = '0;
      c1 = '0;
      if (!rst_n) begin
        rdy[d]  = 1'b0;
        left[d] = clr[d] ? N : 1;
        for (int k = 0; k < 2; k++) begin
          p0[d][k] = '0;
          p1[d][k] = '0;
        end
      end else begin
        if (!rdy[d]) begin
          if (clr[d]) mm[d][N - left[d]] = '0;
          left[d]--;
          if (left[d] == 0) rdy[d] = 1'b1;
        end else begin
          c0 = (wen && waddr == raddr0) ? wdata : mm[d][raddr0];
          c1 = (wen && waddr == raddr1) ? wdata : mm[d][raddr1];
          if (wen) mm[d][waddr] = wdata;
        end
        p0[d][1] = p0[d][0];
        p1[d][1] = p1[d][0];
        p0[d][0] = c0;
        p1[d][0] = c1;
      end
    end
  endtask

  task automatic cmp(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk(string tag);
    for (int d = 0; d < 2; d++) begin
      cmp($sformatf("%s d%0d ready", tag, d), {15'b0, rdy_o[d]}, {15'b0, rdy[d]});
      cmp($sformatf("%s d%0d rdata0", tag, d), rd0[d], p0[d][lat[d]-1]);
      cmp($sformatf("%s d%0d rdata1", tag, d), rd1[d], p1[d][lat[d]-1]);
    end
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk(tag);
  endtask

  task automatic set_wr(logic en, logic [AW-1:0] a, logic [DW-1:0] v);
    wen   = en;
    waddr = a;
    wdata = v;
  endtask

  initial begin
    rst_n  = 1'b0;
    raddr0 = '0;
    raddr1 = '0;
    set_wr(1'b0, '0, '0);
    step("reset");
    step("reset");

    // Release: instance 0 clears for N clocks; fill instance 1 meanwhile.
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_wr(1'b1, AW'(i), DW'($urandom));
      step("first_clear");
    end
    // Fill both with 0xAAAA, then reset and check the clear wipes instance 0.
    for (int i = 0; i < N; i++) begin
      set_wr(1'b1, AW'(i), 16'hAAAA);
      step("fill_aaaa");
    end
    set_wr(1'b0, '0, '0);
    rst_n = 1'b0;
    step("rst2");
    step("rst2");
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) step("clear_aaaa");
    cmp("clear_done ready", {15'b0, rdy_o[0]}, 16'h0001);
    for (int i = 0; i < N + 2; i++) begin
      raddr0 = AW'(i % N);
      raddr1 = AW'((N - 1 - i) % N);
      step("read_cleared");
    end

    // Latency-1 write then read, and same-cycle forwarding on port 1.
    set_wr(1'b1, 4'd5, 16'h1234);
    step("t2_wr");
    set_wr(1'b0, '0, '0);
    raddr0 = 4'd5;
    step("t2_rd");
    cmp("t2 lat1 rdata0", rd0[0], 16'h1234);
    set_wr(1'b1, 4'd5, 16'hBEEF);
    raddr1 = 4'd5;
    step("t2_fwd");
    cmp("t2 lat1 fwd rdata1", rd1[0], 16'hBEEF);

    // Latency-2: a write after capture must not touch in-flight data.
    set_wr(1'b1, 4'd3, 16'h0011);
    step("t3_init");
    set_wr(1'b0, '0, '0);
    raddr0 = 4'd3;
    step("t3_addr");
    set_wr(1'b1, 4'd3, 16'h2222);
    step("t3_wr");
    cmp("t3 lat2 in-flight", rd0[1], 16'h0011);
    set_wr(1'b0, '0, '0);
    step("t3_reread");
    step("t3_reread");
    cmp("t3 lat2 reread", rd0[1], 16'h2222);

    // All-ones address on both ports; address 0 must stay distinct.
    set_wr(1'b1, 4'd0, 16'h0F0F);
    step("t4_zero");
    set_wr(1'b1, 4'd15, 16'hFFFF);
    raddr0 = 4'd15;
    raddr1 = 4'd15;
    step("t4_top");
    cmp("t4 port0 top", rd0[0], 16'hFFFF);
    cmp("t4 port1 top", rd1[0], 16'hFFFF);
    set_wr(1'b0, '0, '0);
    raddr0 = 4'd0;
    step("t4_alias");
    step("t4_alias");
    cmp("t4 no alias", rd0[1], 16'h0F0F);

    // Back-to-back writes with port 1 following the write address.
    for (int i = 1; i <= 4; i++) begin
      set_wr(1'b1, AW'(i), DW'(i * 16'h0101));
      raddr1 = AW'(i);
      step("t6_b2b");
      cmp("t6 fwd lat1", rd1[0], DW'(i * 16'h0101));
    end
    set_wr(1'b0, '0, '0);

    // Reset mid-clear after 9 entries, with wen held high throughout the clear.
    rst_n = 1'b0;
    step("t5_rst");
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_wr(1'b1, AW'($urandom_range(0, N - 1)), DW'($urandom));
      step("t5_partial");
    end
    rst_n = 1'b0;
    step("t5_midrst");
    cmp("t5 midrst ready", {15'b0, rdy_o[0]}, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      set_wr(1'b1, AW'($urandom_range(0, N - 1)), DW'($urandom));
      step("t5_clear");
    end
    set_wr(1'b0, '0, '0);
    for (int i = 0; i < N + 2; i++) begin
      raddr0 = AW'(i % N);
      raddr1 = AW'($urandom_range(0, N - 1));
      step("t5_readback");
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst_n  = ($urandom_range(0, 59) != 0);
      raddr0 = AW'($urandom_range(0, N - 1));
      raddr1 = ($urandom_range(0, 3) == 0) ? raddr0 : AW'($urandom_range(0, N - 1));
      set_wr(1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0) ? raddr0 : AW'($urandom_range(0, N - 1)),
             DW'($urandom));
      step("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
